// File: rtl/audio_feature_extractor.sv
// Single-clock audio analyser: rising-zero-crossing period/pitch class and
// per-frame peak magnitude/loudness class from a valid-qualified PCM stream.
module audio_feature_extractor #(
    parameter int unsigned       DATA_W        = 24,
    parameter int unsigned       PERIOD_W      = 16,
    parameter int unsigned       HYST          = 0,
    parameter int unsigned       PITCH_LOW_TH  = 120,
    parameter int unsigned       PITCH_HIGH_TH = 60,
    parameter int unsigned       FRAME_LEN     = 800,
    parameter logic [DATA_W-1:0] VOL_LO_TH     = 24'h0FFFFF,
    parameter logic [DATA_W-1:0] VOL_HI_TH     = 24'h3FFFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    output logic [PERIOD_W-1:0]      period,
    output logic [1:0]               pitch,
    output logic                     pitch_valid,
    output logic [DATA_W-2:0]        peak,
    output logic [1:0]               volume,
    output logic                     frame_done
);

    localparam int unsigned AW = DATA_W - 1;
    localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_NEG0 = 2'b01;
    localparam logic [1:0] S_POS  = 2'b10;
    localparam logic [1:0] S_NEG  = 2'b11;

    localparam logic [PERIOD_W-1:0]      CNT_MAX   = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0]      CNT_LAST  = CNT_MAX - PERIOD_W'(1);
    localparam logic [AW-1:0]            ABS_MAX   = {AW{1'b1}};
    localparam logic [FW-1:0]            FCNT_LAST = FW'(FRAME_LEN - 1);
    localparam logic signed [DATA_W-1:0] HYST_P    = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_N    = -HYST_P;

    logic [1:0]          state,      state_nxt;
    logic [PERIOD_W-1:0] cnt,        cnt_nxt;
    logic [FW-1:0]       fcnt,       fcnt_nxt;
    logic [AW-1:0]       acc,        acc_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic [1:0]          pitch_nxt;
    logic                pitch_valid_nxt;
    logic [AW-1:0]       peak_nxt;
    logic [1:0]          volume_nxt;
    logic                frame_done_nxt;

    logic                is_pos_c;
    logic                is_neg_c;
    logic [DATA_W-1:0]   neg_c;
    logic [AW-1:0]       abs_c;
    logic [AW-1:0]       max_c;
    logic                cnt_step_c;

    function automatic logic [1:0] pitch_class(input logic [PERIOD_W-1:0] p);
        if (32'(p) > PITCH_LOW_TH)       return 2'b00;
        else if (32'(p) >= PITCH_HIGH_TH) return 2'b01;
        else                              return 2'b11;
    endfunction

    function automatic logic [1:0] volume_class(input logic [AW-1:0] m);
        if ({1'b0, m} >= VOL_HI_TH)      return 2'b11;
        else if ({1'b0, m} >= VOL_LO_TH) return 2'b01;
        else                             return 2'b00;
    endfunction

    // Sample classification and saturating magnitude (most negative code clamps)
    always_comb begin
        is_pos_c = sample > HYST_P;
        is_neg_c = sample < HYST_N;
        neg_c    = ~sample + DATA_W'(1);
        if (!sample[DATA_W-1])   abs_c = sample[AW-1:0];
        else if (neg_c[DATA_W-1]) abs_c = ABS_MAX;
        else                      abs_c = neg_c[AW-1:0];
        max_c    = (abs_c > acc) ? abs_c : acc;
    end

    // Next-state: crossing FSM with period counter, and frame peak tracker
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        period_nxt      = period;
        pitch_nxt       = pitch;
        pitch_valid_nxt = 1'b0;
        fcnt_nxt        = fcnt;
        acc_nxt         = acc;
        peak_nxt        = peak;
        volume_nxt      = volume;
        frame_done_nxt  = 1'b0;
        cnt_step_c      = 1'b0;

        if (sample_valid) begin
            case (state)
                S_INIT: begin
                    if (is_neg_c) state_nxt = S_NEG0;
                end
                S_NEG0: begin
                    if (is_pos_c) begin
                        state_nxt = S_POS;
                        cnt_nxt   = '0;
                    end
                end
                S_POS: begin
                    if (is_neg_c) state_nxt = S_NEG;
                    cnt_step_c = 1'b1;
                end
                S_NEG: begin
                    if (is_pos_c) begin
                        // cnt never exceeds CNT_LAST here, so cnt+1 cannot wrap
                        state_nxt       = S_POS;
                        cnt_nxt         = '0;
                        period_nxt      = cnt + PERIOD_W'(1);
                        pitch_nxt       = pitch_class(cnt + PERIOD_W'(1));
                        pitch_valid_nxt = 1'b1;
                    end else begin
                        cnt_step_c = 1'b1;
                    end
                end
                default: state_nxt = S_INIT;
            endcase

            // Reaching the counter ceiling is the silence timeout
            if (cnt_step_c) begin
                if (cnt == CNT_LAST) begin
                    state_nxt       = S_INIT;
                    cnt_nxt         = '0;
                    period_nxt      = CNT_MAX;
                    pitch_nxt       = 2'b00;
                    pitch_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + PERIOD_W'(1);
                end
            end

            if (fcnt == FCNT_LAST) begin
                fcnt_nxt       = '0;
                acc_nxt        = '0;
                peak_nxt       = max_c;
                volume_nxt     = volume_class(max_c);
                frame_done_nxt = 1'b1;
            end else begin
                fcnt_nxt = fcnt + FW'(1);
                acc_nxt  = max_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_INIT;
            cnt         <= '0;
            fcnt        <= '0;
            acc         <= '0;
            period      <= '0;
            pitch       <= 2'b00;
            pitch_valid <= 1'b0;
            peak        <= '0;
            volume      <= 2'b00;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            fcnt        <= fcnt_nxt;
            acc         <= acc_nxt;
            period      <= period_nxt;
            pitch       <= pitch_nxt;
            pitch_valid <= pitch_valid_nxt;
            peak        <= peak_nxt;
            volume      <= volume_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_audio_feature_extractor.sv
// Scoreboard bench: two configurations of audio_feature_extractor, expected
// pulses queued by the stimulus and consumed by per-instance monitors.
module tb_audio_feature_extractor;

    typedef struct packed {
        logic [15:0] period;
        logic [1:0]  pitch;
    } pexp_t;

    typedef struct packed {
        logic [22:0] peak;
        logic [1:0]  volume;
        logic        both;
    } fexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               sv_a, sv_b;
    logic signed [23:0] s_a, s_b;

    logic [15:0] period_a;
    logic [1:0]  pitch_a, volume_a;
    logic        pv_a, fd_a;
    logic [22:0] peak_a;

    logic [7:0]  period_b;
    logic [1:0]  pitch_b, volume_b;
    logic        pv_b, fd_b;
    logic [22:0] peak_b;

    int n_tests = 0;
    int n_fail  = 0;

    pexp_t pq_a[$];
    pexp_t pq_b[$];
    fexp_t fq_a[$];
    fexp_t fq_b[$];

    logic chk_fb = 1'b0;
    logic vq_a = 1'b0;
    logic vq_b = 1'b0;

    audio_feature_extractor #(
        .FRAME_LEN (800)
    ) u_a (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sv_a),
        .sample       (s_a),
        .period       (period_a),
        .pitch        (pitch_a),
        .pitch_valid  (pv_a),
        .peak         (peak_a),
        .volume       (volume_a),
        .frame_done   (fd_a)
    );

    audio_feature_extractor #(
        .HYST      (100),
        .PERIOD_W  (8),
        .FRAME_LEN (4)
    ) u_b (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sv_b),
        .sample       (s_b),
        .period       (period_b),
        .pitch        (pitch_b),
        .pitch_valid  (pv_b),
        .peak         (peak_b),
        .volume       (volume_b),
        .frame_done   (fd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Valid seen by the edge that produced the outputs now visible
    always @(posedge clk) begin
        vq_a <= sv_a;
        vq_b <= sv_b;
    end

    // Monitor for instance A
    always @(negedge clk) begin
        pexp_t pe;
        fexp_t fe;
        if (pv_a || fd_a) check("a_pulse_after_valid", 32'(vq_a), 32'd1);
        if (pv_a) begin
            if (pq_a.size() == 0) begin
                check("a_pitch_unexpected", 32'(period_a), 32'hFFFF_FFFF);
            end else begin
                pe = pq_a.pop_front();
                check("a_period", 32'(period_a), 32'(pe.period));
                check("a_pitch", 32'(pitch_a), 32'(pe.pitch));
            end
        end
        if (fd_a) begin
            if (fq_a.size() == 0) begin
                check("a_frame_unexpected", 32'(peak_a), 32'hFFFF_FFFF);
            end else begin
                fe = fq_a.pop_front();
                check("a_peak", 32'(peak_a), 32'(fe.peak));
                check("a_volume", 32'(volume_a), 32'(fe.volume));
                check("a_coincident_pitch", 32'(pv_a), 32'(fe.both));
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        pexp_t pe;
        fexp_t fe;
        if (pv_b || fd_b) check("b_pulse_after_valid", 32'(vq_b), 32'd1);
        if (pv_b) begin
            if (pq_b.size() == 0) begin
                check("b_pitch_unexpected", 32'(period_b), 32'hFFFF_FFFF);
            end else begin
                pe = pq_b.pop_front();
                check("b_period", 32'(period_b), 32'(pe.period));
                check("b_pitch", 32'(pitch_b), 32'(pe.pitch));
            end
        end
        if (fd_b && chk_fb) begin
            if (fq_b.size() == 0) begin
                check("b_frame_unexpected", 32'(peak_b), 32'hFFFF_FFFF);
            end else begin
                fe = fq_b.pop_front();
                check("b_peak", 32'(peak_b), 32'(fe.peak));
                check("b_volume", 32'(volume_b), 32'(fe.volume));
            end
        end
    end

    task automatic exp_pa(input int p, input logic [1:0] c);
        pexp_t e;
        e.period = 16'(p);
        e.pitch  = c;
        pq_a.push_back(e);
    endtask

    task automatic exp_pb(input int p, input logic [1:0] c);
        pexp_t e;
        e.period = 16'(p);
        e.pitch  = c;
        pq_b.push_back(e);
    endtask

    task automatic exp_fa(input logic [22:0] pk, input logic [1:0] v, input logic both);
        fexp_t e;
        e.peak   = pk;
        e.volume = v;
        e.both   = both;
        fq_a.push_back(e);
    endtask

    task automatic exp_fb(input logic [22:0] pk, input logic [1:0] v);
        fexp_t e;
        e.peak   = pk;
        e.volume = v;
        e.both   = 1'b0;
        fq_b.push_back(e);
    endtask

    task automatic send_a(input logic signed [23:0] s);
        s_a  = s;
        sv_a = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic signed [23:0] s);
        s_b  = s;
        sv_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rep_a(input logic signed [23:0] s, input int n);
        repeat (n) send_a(s);
    endtask

    task automatic rep_b(input logic signed [23:0] s, input int n);
        repeat (n) send_b(s);
    endtask

    task automatic idle(input int n);
        sv_a = 1'b0;
        sv_b = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        idle(1);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    // Square wave on A starting with a low half; n measured periods
    task automatic square_a(input int half, input int n, input int p, input logic [1:0] c);
        rep_a(-1000, half);
        for (int i = 0; i < n; i++) begin
            if (i > 0) exp_pa(p, c);
            rep_a(1000, half);
            rep_a(-1000, half);
        end
        exp_pa(p, c);
        send_a(1000);
        idle(2);
    endtask

    // One half cycle of the noisy period-8 wave on B
    task automatic noisy_half_b(input logic signed [23:0] lvl, input logic signed [23:0] noise);
        send_b(lvl);
        send_b(lvl);
        send_b(noise);
        send_b(lvl);
    endtask

    task automatic gap_a(input logic signed [23:0] s);
        send_a(s);
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        sv_a  = 1'b0;
        sv_b  = 1'b0;
        s_a   = '0;
        s_b   = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset values
        check("rst_a_period", 32'(period_a), 32'd0);
        check("rst_a_pitch", 32'(pitch_a), 32'd0);
        check("rst_a_pv", 32'(pv_a), 32'd0);
        check("rst_a_peak", 32'(peak_a), 32'd0);
        check("rst_a_volume", 32'(volume_a), 32'd0);
        check("rst_a_fd", 32'(fd_a), 32'd0);
        check("rst_b_period", 32'(period_b), 32'd0);
        check("rst_b_peak", 32'(peak_b), 32'd0);

        // Volume frames of 4 on B
        chk_fb = 1'b1;
        send_b(0); send_b(-5); send_b(3);
        exp_fb(23'd5, 2'b00);
        send_b(2);
        send_b(24'sh800000); send_b(0); send_b(0);
        exp_fb(23'h7FFFFF, 2'b11);
        send_b(0);
        send_b(24'sh100000); send_b(0); send_b(0);
        exp_fb(23'h100000, 2'b01);
        send_b(0);
        idle(3);
        chk_fb = 1'b0;

        // Square 4/4 on A
        square_a(4, 3, 8, 2'b11);

        // Asynchronous reset mid-period clears outputs at once
        rep_a(-1000, 3);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_a_period", 32'(period_a), 32'd0);
        check("midrst_a_pitch", 32'(pitch_a), 32'd0);
        check("midrst_a_pv", 32'(pv_a), 32'd0);
        check("midrst_a_fd", 32'(fd_a), 32'd0);
        check("midrst_b_peak", 32'(peak_b), 32'd0);
        check("midrst_b_volume", 32'(volume_b), 32'd0);
        sv_a = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // First crossing after reset is only a reference
        send_a(1000);
        rep_a(-1000, 4);
        rep_a(1000, 4);
        rep_a(-1000, 4);
        exp_pa(8, 2'b11);
        send_a(1000);
        idle(2);

        do_reset();
        square_a(40, 3, 80, 2'b01);
        do_reset();
        square_a(100, 3, 200, 2'b00);
        do_reset();

        // Hysteresis on B: opposite-sign noise inside each half cycle
        noisy_half_b(-1000, 50);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) exp_pb(8, 2'b11);
            noisy_half_b(1000, -50);
            noisy_half_b(-1000, 50);
        end
        exp_pb(8, 2'b11);
        send_b(1000);
        idle(2);
        do_reset();

        // Silence timeout on B (8-bit counter)
        send_b(-1000);
        send_b(1000);
        exp_pb(255, 2'b00);
        rep_b(5, 300);
        send_b(1000);
        send_b(-1000);
        rep_b(1000, 4);
        rep_b(-1000, 4);
        exp_pb(8, 2'b11);
        send_b(1000);
        idle(2);
        do_reset();

        // Gapped valid on A; measured crossing on the last sample of the frame
        for (int i = 0; i < 79; i++) gap_a(-24'sh200000);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) exp_pa(80, 2'b01);
            for (int j = 0; j < 40; j++) gap_a(24'sh200000);
            for (int j = 0; j < 40; j++) gap_a(-24'sh200000);
        end
        exp_pa(80, 2'b01);
        exp_fa(23'h200000, 2'b01, 1'b1);
        gap_a(24'sh200000);
        idle(5);

        check("a_pitch_left", 32'(pq_a.size()), 32'd0);
        check("b_pitch_left", 32'(pq_b.size()), 32'd0);
        check("a_frame_left", 32'(fq_a.size()), 32'd0);
        check("b_frame_left", 32'(fq_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
